// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Lets two requester ports share one asynchronous SRAM. Requests are arbitrated
// round-robin. The winning request's fields are latched at grant. The SRAM
// strobes are sequenced through SETUP, ACCESS (WAIT_CYCLES cycles) and HOLD.
// The completion ack is a single-cycle pulse during HOLD.
// All outputs are registered. rst is asynchronous and active-high.

module sram_port_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2   // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,

  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  input  logic [DW-1:0] sram_din,
  output logic          sram_de,
  output logic          sram_ncs,
  output logic          sram_noe,
  output logic          sram_nwe,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The ACCESS counter runs from WAIT_CYCLES-1 down to 0.
  // The strobe phase therefore lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic        last_grant;   // port that won the most recent grant
  logic        cur_port;     // port owning the transaction in flight
  logic        we_reg;       // latched direction of the transaction in flight
  logic [3:0]  wait_cnt;

  logic        grant_valid;
  logic        grant_port;
  logic        grant_we;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;

  // Round-robin choice: a lone requester wins; on a tie the port that did not win last time wins
  always_comb begin
    grant_valid = r0_req | r1_req;
    grant_port  = 1'b0;
    if (r0_req && r1_req) begin
      grant_port = ~last_grant;
    end else if (r1_req) begin
      grant_port = 1'b1;
    end
    grant_we    = grant_port ? r1_we    : r0_we;
    grant_addr  = grant_port ? r1_addr  : r0_addr;
    grant_wdata = grant_port ? r1_wdata : r0_wdata;
  end

  // Transaction FSM with registered SRAM strobes, acks and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      we_reg     <= 1'b0;
      wait_cnt   <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_de    <= 1'b0;
      sram_ncs   <= 1'b1;
      sram_noe   <= 1'b1;
      sram_nwe   <= 1'b1;
      busy       <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      // Acks are one-cycle pulses unless re-armed below.
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= SETUP;
            busy       <= 1'b1;
            cur_port   <= grant_port;
            last_grant <= grant_port;
            we_reg     <= grant_we;
            sram_addr  <= grant_addr;
            sram_dout  <= grant_wdata;
            // Chip select and pad drive come up one cycle ahead of the strobe.
            sram_ncs   <= 1'b0;
            sram_de    <= grant_we;
          end
        end

        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= WAIT_LOAD;
          if (we_reg) begin
            sram_nwe <= 1'b0;
          end else begin
            sram_noe <= 1'b0;
          end
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state    <= HOLD;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            // Read data is sampled on the edge that closes the strobe window.
            if (!we_reg) begin
              if (cur_port) begin
                r1_rdata <= sram_din;
              end else begin
                r0_rdata <= sram_din;
              end
            end
            if (cur_port) begin
              r1_ack <= 1'b1;
            end else begin
              r0_ack <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        HOLD: begin
          // Chip select and data drive were kept through HOLD for write data hold time.
          state    <= IDLE;
          sram_ncs <= 1'b1;
          sram_de  <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
